// File: rtl/csa_accumulator_pipe_if.sv
// Beat-in / redundant-result-out handshake bundle for csa_accumulator_pipe.
interface csa_accumulator_pipe_if #(
    parameter int XLEN  = 49,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_first;
    logic             in_last;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [XLEN-1:0]  op_c;
    logic [XLEN-1:0]  op_d;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_sum;
    logic [XLEN-1:0]  out_carry;
    logic [CNT_W-1:0] out_beats;

    modport master (
        output in_valid, in_first, in_last, op_a, op_b, op_c, op_d, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_beats
    );

    modport slave (
        input  in_valid, in_first, in_last, op_a, op_b, op_c, op_d, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_beats
    );
endinterface

// File: rtl/csa_accumulator_pipe.sv
// Two-stage carry-save accumulator: a 4:2 reduction of each beat, then a 4:2 fold of that
// beat into a redundant (sum, carry) accumulator; the closing beat's value is held for output.
module csa_accumulator_pipe #(
    parameter int XLEN  = 49,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    csa_accumulator_pipe_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Full-adder row; result packed as {carry (already weight-aligned), sum}.
    function automatic logic [2*XLEN-1:0] csa32(input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b,
                                                input logic [XLEN-1:0] c);
        logic [XLEN-1:0] maj;
        maj = (a & b) | (a & c) | (b & c);
        return {maj[XLEN-2:0], 1'b0, a ^ b ^ c};
    endfunction

    function automatic logic [2*XLEN-1:0] compress42(input logic [XLEN-1:0] a,
                                                     input logic [XLEN-1:0] b,
                                                     input logic [XLEN-1:0] c,
                                                     input logic [XLEN-1:0] d);
        logic [2*XLEN-1:0] l1;
        l1 = csa32(a, b, c);
        return csa32(l1[XLEN-1:0], l1[2*XLEN-1:XLEN], d);
    endfunction

    logic             s1_valid_q, s1_first_q, s1_last_q;
    logic [XLEN-1:0]  s1_sum_q, s1_carry_q;
    logic [XLEN-1:0]  acc_sum_q, acc_carry_q;
    logic [CNT_W-1:0] beat_cnt_q;
    logic             out_valid_q;
    logic [XLEN-1:0]  out_sum_q, out_carry_q;
    logic [CNT_W-1:0] out_beats_q;

    logic             s1_go_s, in_fire_s, out_pop_s;
    logic [XLEN-1:0]  base_sum_s, base_carry_s;
    logic [CNT_W-1:0] base_cnt_s, beat_cnt_d;
    logic [2*XLEN-1:0] s1_red_d, acc_red_d;

    // Handshake decisions and next-state arithmetic for both stages.
    always_comb begin
        s1_go_s   = s1_valid_q & (~s1_last_q | ~out_valid_q | bus.out_ready);
        in_fire_s = bus.in_valid & (~s1_valid_q | s1_go_s);
        out_pop_s = out_valid_q & bus.out_ready;
        s1_red_d  = compress42(bus.op_a, bus.op_b, bus.op_c, bus.op_d);
        if (s1_first_q) begin
            base_sum_s   = '0;
            base_carry_s = '0;
            base_cnt_s   = '0;
        end else begin
            base_sum_s   = acc_sum_q;
            base_carry_s = acc_carry_q;
            base_cnt_s   = beat_cnt_q;
        end
        acc_red_d = compress42(base_sum_s, base_carry_s, s1_sum_q, s1_carry_q);
        if (base_cnt_s == CNT_MAX) begin
            beat_cnt_d = CNT_MAX;
        end else begin
            beat_cnt_d = base_cnt_s + CNT_W'(1);
        end
    end

    assign bus.in_ready  = ~s1_valid_q | s1_go_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_carry = out_carry_q;
    assign bus.out_beats = out_beats_q;

    // Stage 1: per-beat 4:2 reduction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sum_q   <= '0;
            s1_carry_q <= '0;
        end else if (in_fire_s) begin
            s1_valid_q <= 1'b1;
            s1_first_q <= bus.in_first;
            s1_last_q  <= bus.in_last;
            s1_sum_q   <= s1_red_d[XLEN-1:0];
            s1_carry_q <= s1_red_d[2*XLEN-1:XLEN];
        end else if (s1_go_s) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Stage 2: accumulator fold and output register; a new load beats a same-cycle pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum_q   <= '0;
            acc_carry_q <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= '0;
            out_beats_q <= '0;
        end else if (s1_go_s && s1_last_q) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= acc_red_d[XLEN-1:0];
            out_carry_q <= acc_red_d[2*XLEN-1:XLEN];
            out_beats_q <= beat_cnt_d;
            acc_sum_q   <= '0;
            acc_carry_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            if (s1_go_s) begin
                acc_sum_q   <= acc_red_d[XLEN-1:0];
                acc_carry_q <= acc_red_d[2*XLEN-1:XLEN];
                beat_cnt_q  <= beat_cnt_d;
            end
            if (out_pop_s) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_csa_accumulator_pipe.sv
// Directed tests on an 8-bit/2-bit-counter instance plus a randomized scoreboard run on the
// default-width instance, with expected values from plain modular sums of the operands.
module tb_csa_accumulator_pipe;
    localparam int XS = 8;
    localparam int CS = 2;
    localparam int XL = 49;
    localparam int CL = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    csa_accumulator_pipe_if #(.XLEN(XS), .CNT_W(CS)) if8 ();
    csa_accumulator_pipe_if #(.XLEN(XL), .CNT_W(CL)) ifw ();

    csa_accumulator_pipe #(.XLEN(XS), .CNT_W(CS)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    csa_accumulator_pipe #(.XLEN(XL), .CNT_W(CL)) u_dutw (.clk(clk), .rst_n(rst_n), .bus(ifw));

    task automatic drive8(input logic v, input logic f, input logic l,
                          input logic [XS-1:0] a, input logic [XS-1:0] b,
                          input logic [XS-1:0] c, input logic [XS-1:0] d);
        if8.in_valid = v;
        if8.in_first = f;
        if8.in_last  = l;
        if8.op_a = a;
        if8.op_b = b;
        if8.op_c = c;
        if8.op_d = d;
    endtask

    function automatic logic [XS-1:0] red8();
        logic [XS-1:0] r;
        r = if8.out_sum + if8.out_carry;
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive8(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        if8.out_ready = 1'b1;
        ifw.in_valid = 1'b0; ifw.in_first = 1'b0; ifw.in_last = 1'b0;
        ifw.op_a = '0; ifw.op_b = '0; ifw.op_c = '0; ifw.op_d = '0;
        ifw.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({if8.out_valid, if8.out_sum, if8.out_carry, if8.out_beats} !== '0)
            begin n_err++; $display("FAIL reset8: out=%h required 0", {if8.out_valid, if8.out_sum, if8.out_carry, if8.out_beats}); end
        n_vec++;
        if ({ifw.out_valid, ifw.out_sum, ifw.out_carry, ifw.out_beats} !== '0)
            begin n_err++; $display("FAIL resetw: out=%h required 0", {ifw.out_valid, ifw.out_sum, ifw.out_carry, ifw.out_beats}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if ({if8.in_ready, ifw.in_ready} !== 2'b11)
            begin n_err++; $display("FAIL reset_ready: in_ready=%b required 11", {if8.in_ready, ifw.in_ready}); end
    endtask

    task automatic test_single_beat();
        @(negedge clk);
        drive8(1'b1, 1'b1, 1'b1, 8'd1, 8'd2, 8'd3, 8'd4);
        #1;
        n_vec++;
        if (if8.in_ready !== 1'b1) begin n_err++; $display("FAIL t1_ready: got %b required 1", if8.in_ready); end
        @(negedge clk);
        drive8(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        #1;
        n_vec++;
        if (if8.out_valid !== 1'b0) begin n_err++; $display("FAIL t1_early: out_valid=%b required 0", if8.out_valid); end
        @(negedge clk);
        #1;
        n_vec++;
        if ({if8.out_valid, red8(), if8.out_beats} !== {1'b1, 8'd10, 2'd1})
            begin n_err++; $display("FAIL t1_result: valid=%b sum=%0d beats=%0d required 1/10/1", if8.out_valid, red8(), if8.out_beats); end
        @(negedge clk);
        #1;
        n_vec++;
        if (if8.out_valid !== 1'b0) begin n_err++; $display("FAIL t1_pop: out_valid=%b required 0", if8.out_valid); end
    endtask

    task automatic wait_out8(input string tag, output logic got);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            #1;
            if (if8.out_valid === 1'b1) got = 1'b1;
        end
        n_vec++;
        if (!got) begin n_err++; $display("FAIL %s_timeout: out_valid=0 required 1", tag); end
    endtask

    task automatic test_multi_beat();
        logic got;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive8(1'b1, i == 0, i == 2, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        end
        @(negedge clk);
        drive8(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_out8("t2", got);
        n_vec++;
        if ({red8(), if8.out_beats} !== {8'hF4, 2'd3})
            begin n_err++; $display("FAIL t2_result: sum=%h beats=%0d required f4/3", red8(), if8.out_beats); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        if8.out_ready = 1'b0;
        drive8(1'b1, 1'b1, 1'b1, 8'd1, 8'd1, 8'd1, 8'd1);
        @(negedge clk);
        drive8(1'b1, 1'b1, 1'b1, 8'd2, 8'd2, 8'd2, 8'd2);
        #1;
        n_vec++;
        if (if8.in_ready !== 1'b1) begin n_err++; $display("FAIL t3_accept_b: in_ready=%b required 1", if8.in_ready); end
        @(negedge clk);
        drive8(1'b1, 1'b1, 1'b1, 8'd3, 8'd3, 8'd3, 8'd3);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if ({if8.in_ready, if8.out_valid, red8(), if8.out_beats} !== {1'b0, 1'b1, 8'd4, 2'd1})
                begin n_err++; $display("FAIL t3_hold: ready=%b valid=%b sum=%0d beats=%0d required 0/1/4/1", if8.in_ready, if8.out_valid, red8(), if8.out_beats); end
            @(negedge clk);
        end
        if8.out_ready = 1'b1;
        #1;
        n_vec++;
        if (if8.in_ready !== 1'b1) begin n_err++; $display("FAIL t3_release: in_ready=%b required 1", if8.in_ready); end
        @(negedge clk);
        drive8(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        #1;
        n_vec++;
        if ({if8.out_valid, red8()} !== {1'b1, 8'd8})
            begin n_err++; $display("FAIL t3_second: valid=%b sum=%0d required 1/8", if8.out_valid, red8()); end
        @(negedge clk);
        #1;
        n_vec++;
        if ({if8.out_valid, red8()} !== {1'b1, 8'd12})
            begin n_err++; $display("FAIL t3_third: valid=%b sum=%0d required 1/12", if8.out_valid, red8()); end
        @(negedge clk);
        #1;
        n_vec++;
        if (if8.out_valid !== 1'b0) begin n_err++; $display("FAIL t3_drain: out_valid=%b required 0", if8.out_valid); end
    endtask

    task automatic test_reset_mid_group();
        logic got;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive8(1'b1, i == 0, 1'b0, 8'd7, 8'd7, 8'd7, 8'd7);
        end
        @(negedge clk);
        drive8(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({if8.out_valid, if8.out_sum, if8.out_carry, if8.out_beats, if8.in_ready} !== {19'd0, 1'b1})
            begin n_err++; $display("FAIL t4_async: out=%h in_ready=%b required 0/1", {if8.out_valid, if8.out_sum, if8.out_carry, if8.out_beats}, if8.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive8(1'b1, 1'b0, 1'b1, 8'd5, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        drive8(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_out8("t4", got);
        n_vec++;
        if ({red8(), if8.out_beats} !== {8'd5, 2'd1})
            begin n_err++; $display("FAIL t4_result: sum=%0d beats=%0d required 5/1", red8(), if8.out_beats); end
    endtask

    task automatic test_saturation();
        logic got;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive8(1'b1, i == 0, i == 5, 8'd1, 8'd0, 8'd0, 8'd0);
        end
        @(negedge clk);
        drive8(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_out8("t5", got);
        n_vec++;
        if ({red8(), if8.out_beats} !== {8'd6, 2'd3})
            begin n_err++; $display("FAIL t5_result: sum=%0d beats=%0d required 6/3", red8(), if8.out_beats); end
    endtask

    task automatic test_random();
        logic [XL-1:0] exp_sum_q[$];
        logic [CL-1:0] exp_beats_q[$];
        logic [XL-1:0] g_sum, h_sum, h_carry, es, rs;
        logic [CL-1:0] h_beats, eb;
        logic          hold;
        int            g_cnt, beats, drain;
        g_sum = '0; g_cnt = 0; beats = 0; drain = 0; hold = 1'b0;
        h_sum = '0; h_carry = '0; h_beats = '0;
        for (int cyc = 0; cyc < 60000 && drain < 20; cyc++) begin
            @(negedge clk);
            if (beats < 10000) begin
                ifw.in_valid  = ($urandom_range(0, 9) < 7);
                ifw.in_first  = ($urandom_range(0, 7) == 0);
                ifw.in_last   = ($urandom_range(0, 3) == 0);
                ifw.op_a      = XL'({$urandom, $urandom});
                ifw.op_b      = XL'({$urandom, $urandom});
                ifw.op_c      = XL'({$urandom, $urandom});
                ifw.op_d      = XL'({$urandom, $urandom});
                ifw.out_ready = ($urandom_range(0, 9) < 6);
            end else begin
                ifw.in_valid  = 1'b0;
                ifw.out_ready = 1'b1;
                drain++;
            end
            #1;
            if (hold) begin
                n_vec++;
                if ({ifw.out_valid, ifw.out_sum, ifw.out_carry, ifw.out_beats} !== {1'b1, h_sum, h_carry, h_beats})
                    begin n_err++; $display("FAIL t6_hold: cycle %0d out changed while stalled", cyc); end
            end
            if (ifw.out_valid === 1'b1 && ifw.out_ready === 1'b1) begin
                n_vec++;
                if (exp_sum_q.size() == 0) begin
                    n_err++; $display("FAIL t6_extra: cycle %0d result with no completed group", cyc);
                end else begin
                    es = exp_sum_q.pop_front();
                    eb = exp_beats_q.pop_front();
                    rs = ifw.out_sum + ifw.out_carry;
                    if ({rs, ifw.out_beats} !== {es, eb})
                        begin n_err++; $display("FAIL t6_result: sum=%h beats=%0d required %h/%0d", rs, ifw.out_beats, es, eb); end
                end
            end
            hold    = ifw.out_valid & ~ifw.out_ready;
            h_sum   = ifw.out_sum;
            h_carry = ifw.out_carry;
            h_beats = ifw.out_beats;
            if (ifw.in_valid === 1'b1 && ifw.in_ready === 1'b1) begin
                if (ifw.in_first) begin g_sum = '0; g_cnt = 0; end
                g_sum = g_sum + ifw.op_a + ifw.op_b + ifw.op_c + ifw.op_d;
                g_cnt++;
                beats++;
                if (ifw.in_last) begin
                    exp_sum_q.push_back(g_sum);
                    exp_beats_q.push_back(CL'((g_cnt > 255) ? 255 : g_cnt));
                    g_sum = '0;
                    g_cnt = 0;
                end
            end
        end
        n_vec++;
        if (beats < 10000 || exp_sum_q.size() != 0)
            begin n_err++; $display("FAIL t6_complete: beats=%0d pending=%0d required 10000/0", beats, exp_sum_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_back_to_back();
        test_reset_mid_group();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
